wt_mem_req_arbiter: RTL and testbench
=====================================

Name: wt_mem_req_arbiter

Overview:
- Shares the single write-through memory port (NOC_TYPE_AXI4_ATOP side) between three requesters: icache refill, dcache load miss and dcache write-through store.
- Selects a winner round-robin and holds it in an output register that stays stable under backpressure.
- Caps transactions in flight at the configured MaxOutstandingStores.
- Runs a fence-drain sequence for the fence/fence.i controller.

Parameters:
NrReq, 3, number of requesters (0=icache, 1=dcache load, 2=dcache store)
MaxOutstanding, 7, max accepted-but-unresponded transactions (cva6_cfg.MaxOutstandingStores)
PayloadWidth, 136, opaque request payload bits (addr, data, be, we, tid)
CntWidth, 3, width of the in-flight counter; must hold MaxOutstanding

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_valid_i  in  NrReq  per-requester request valid
req_ready_o  out  NrReq  per-requester accept; at most one bit high per cycle
req_payload_i  in  NrReq*PayloadWidth  per-requester payload, requester i at bits [i*PayloadWidth +: PayloadWidth]
mem_valid_o  out  1  output register holds a request
mem_ready_i  in  1  downstream accepts
mem_payload_o  out  PayloadWidth  registered payload
mem_src_o  out  2  requester index of the registered request
rsp_valid_i  in  1  one transaction completed downstream
fence_i  in  1  one-cycle fence request pulse
fence_busy_o  out  1  fence drain in progress
fence_done_o  out  1  one-cycle pulse when drain complete
outstanding_o  out  CntWidth  current in-flight count
err_o  out  1  sticky: rsp_valid_i received while the count was 0

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous and active-low on rst_ni. All state is sampled on the rising edge.
- Reset values:
  - mem_valid_o=0, mem_payload_o=0, mem_src_o=0
  - outstanding_o=0, fence_busy_o=0, fence_done_o=0, err_o=0
  - RR pointer=NrReq-1, so requester 0 wins first
  - FSM=IDLE
- A reset asserted mid-operation discards the held request and the count. No req_ready_o is asserted in the reset cycle.
- Load enable: load = (!mem_valid_o | mem_ready_i) & (outstanding_o < MaxOutstanding) & (state==IDLE).
- Arbitration:
  - When load=1 and any req_valid_i is set, the winner is the first valid index searching from ptr+1, wrapping modulo NrReq.
  - For the winner: req_ready_o[w]=1 in the same cycle (combinational). The next cycle has mem_valid_o=1, mem_payload_o=payload[w], mem_src_o=w, ptr=w.
  - Request-to-mem_valid_o latency is 1 cycle.
- Output register:
  - Holds its value while mem_valid_o & !mem_ready_i. Payload and src must not change during that time.
  - Clears on handshake unless it is reloaded in the same cycle; back-to-back throughput is 1 per cycle.
- Counter:
  - +1 on acceptance (any req_ready_o bit).
  - -1 on rsp_valid_i.
  - Both in the same cycle: unchanged.
  - rsp_valid_i at count 0: count stays 0 and err_o is set until reset.
  - The count never exceeds MaxOutstanding.
- Fence FSM:
  - IDLE -> DRAIN on fence_i. fence_busy_o=1 from the next cycle. No acceptances while in DRAIN; the held request still completes normally.
  - DRAIN -> DONE when !mem_valid_o & outstanding_o==0.
  - DONE: fence_done_o=1 for exactly one cycle, then IDLE. Acceptance resumes the cycle after DONE.
  - fence_i while not IDLE is ignored.
  - fence_i with nothing pending: DRAIN 1 cycle, then DONE. fence_done_o is high 2 cycles after fence_i.
- Requesters may drop req_valid_i without being accepted; no state changes in that case.

Test Plan:
- RR fairness: all three req_valid_i held high, mem_ready_i=1, rsp_valid_i every cycle -> mem_src_o sequence 0,1,2,0,1,2; outstanding_o stays at 1 or below.
- Backpressure: accept req1 (payload 0xA5), then mem_ready_i=0 for 5 cycles -> mem_payload_o=0xA5 and mem_src_o=1 stable, req_ready_o=0 throughout; mem_ready_i=1 -> the next winner loads the following cycle.
- Limit: mem_ready_i=1, no responses, req0 always valid -> exactly 7 acceptances, outstanding_o=7, req_ready_o stays 0; one rsp_valid_i -> acceptance the next cycle, count returns to 7.
- Simultaneous events: count=3, acceptance and rsp_valid_i in the same cycle -> count stays 3; rsp_valid_i at count 0 -> count 0, err_o=1 sticky.
- Fence: 3 outstanding, fence_i pulse, req2 valid -> fence_busy_o=1, no acceptances; after the 3rd rsp, fence_done_o pulses for 1 cycle; req2 is accepted the cycle after the pulse.
- Reset mid-burst: rst_ni=0 for 1 cycle with mem_valid_o=1 and count=5 -> all outputs at reset values; the first subsequent grant goes to requester 0.

Source files
------------

// File: rtl/wt_mem_req_arbiter.sv
// Write-through memory request arbiter.
// Shares one memory port between icache refill, dcache load miss and dcache
// store. It picks a round-robin winner into a backpressure-stable output
// register, caps the number of in-flight transactions, and drains for fences.
module wt_mem_req_arbiter #(
  parameter int NrReq          = 3,
  parameter int MaxOutstanding = 7,
  parameter int PayloadWidth   = 136,
  parameter int CntWidth       = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NrReq-1:0]              req_valid_i,
  output logic [NrReq-1:0]              req_ready_o,
  input  logic [NrReq*PayloadWidth-1:0] req_payload_i,
  output logic                          mem_valid_o,
  input  logic                          mem_ready_i,
  output logic [PayloadWidth-1:0]       mem_payload_o,
  output logic [1:0]                    mem_src_o,
  input  logic                          rsp_valid_i,
  input  logic                          fence_i,
  output logic                          fence_busy_o,
  output logic                          fence_done_o,
  output logic [CntWidth-1:0]           outstanding_o,
  output logic                          err_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  typedef enum logic [1:0] {
    FENCE_IDLE,
    FENCE_DRAIN,
    FENCE_DONE
  } fence_state_e;

  fence_state_e              state_q, state_d;
  logic [1:0]                ptr_q;
  logic                      mem_valid_q;
  logic [PayloadWidth-1:0]   mem_payload_q;
  logic [1:0]                mem_src_q;
  logic [CntWidth-1:0]       cnt_q;
  logic                      err_q;

  logic                      load;
  logic                      found;
  logic [1:0]                winner;
  logic [PayloadWidth-1:0]   win_payload;
  logic                      grant;
  logic                      rsp_eff;
  int                        idx;

  // Output register may take a new request when it is empty or draining this
  // cycle, the in-flight budget is not used up, and no fence is pending.
  // Gating with rst_ni keeps every ready low during the reset cycle.
  assign load = rst_ni
              & (~mem_valid_q | mem_ready_i)
              & (cnt_q < MaxCnt)
              & (state_q == FENCE_IDLE);

  // Round-robin search: first valid requester after the last winner.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    found       = 1'b0;
    winner      = '0;
    win_payload = '0;
    idx         = 0;
    for (int off = 1; off <= NrReq; off++) begin
      idx = (int'(ptr_q) + off) % NrReq;
      if (!found && req_valid_i[idx]) begin
        found       = 1'b1;
        winner      = 2'(idx);
        win_payload = req_payload_i[idx*PayloadWidth +: PayloadWidth];
      end
    end
  end

  assign grant = load & found;

  // One-hot accept toward the winning requester, same cycle as its valid.
  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[winner] = 1'b1;
    end
  end

  // A response at count zero is spurious: it is flagged and never decrements.
  assign rsp_eff = rsp_valid_i & (cnt_q != '0);

  // Output register and round-robin pointer.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      mem_valid_q   <= 1'b0;
      mem_payload_q <= '0;
      mem_src_q     <= '0;
      ptr_q         <= 2'(NrReq - 1);
    end else if (grant) begin
      mem_valid_q   <= 1'b1;
      mem_payload_q <= win_payload;
      mem_src_q     <= winner;
      ptr_q         <= winner;
    end else if (mem_ready_i) begin
      // Handshake without reload empties the slot; payload/src are don't-care.
      mem_valid_q   <= 1'b0;
    end
  end

  // In-flight counter and sticky spurious-response flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant && !rsp_eff) begin
        cnt_q <= cnt_q + CntOne;
      end else if (!grant && rsp_eff) begin
        cnt_q <= cnt_q - CntOne;
      end
      if (rsp_valid_i && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Fence state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FENCE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fence next-state and status decode.
  always_comb begin
    state_d      = state_q;
    fence_busy_o = 1'b0;
    fence_done_o = 1'b0;
    unique case (state_q)
      FENCE_IDLE: begin
        if (fence_i) begin
          state_d = FENCE_DRAIN;
        end
      end
      FENCE_DRAIN: begin
        fence_busy_o = 1'b1;
        if (!mem_valid_q && (cnt_q == '0)) begin
          state_d = FENCE_DONE;
        end
      end
      FENCE_DONE: begin
        fence_done_o = 1'b1;
        state_d      = FENCE_IDLE;
      end
      default: begin
        state_d = FENCE_IDLE;
      end
    endcase
  end

  assign mem_valid_o   = mem_valid_q;
  assign mem_payload_o = mem_payload_q;
  assign mem_src_o     = mem_src_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Directed self-checking bench for wt_mem_req_arbiter.
module tb_wt_mem_req_arbiter;

  localparam int NrReq = 3;
  localparam int PW    = 136;
  localparam int CW    = 3;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [NrReq-1:0]      req_valid;
  logic [NrReq-1:0]      req_ready;
  logic [NrReq*PW-1:0]   req_payload;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [PW-1:0]         mem_payload;
  logic [1:0]            mem_src;
  logic                  rsp_valid;
  logic                  fence;
  logic                  fence_busy;
  logic                  fence_done;
  logic [CW-1:0]         outstanding;
  logic                  err;

  int n_checks = 0;
  int n_errors = 0;

  wt_mem_req_arbiter #(
    .NrReq(NrReq), .MaxOutstanding(7), .PayloadWidth(PW), .CntWidth(CW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_payload_i (req_payload),
    .mem_valid_o   (mem_valid),
    .mem_ready_i   (mem_ready),
    .mem_payload_o (mem_payload),
    .mem_src_o     (mem_src),
    .rsp_valid_i   (rsp_valid),
    .fence_i       (fence),
    .fence_busy_o  (fence_busy),
    .fence_done_o  (fence_done),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic set_pay(input int i, input logic [PW-1:0] v);
    req_payload[i*PW +: PW] = v;
  endtask

  initial begin
    int acc;
    int seq [5];
    logic [2:0] oh;

    rst_ni    = 1'b0;
    req_valid = '0;
    req_payload = '0;
    mem_ready = 1'b0;
    rsp_valid = 1'b0;
    fence     = 1'b0;

    // ---------------- reset state ----------------
    tick();
    req_valid = 3'b111;
    settle();
    check("ready_in_reset", req_ready, 3'b000);
    tick();
    check("rst_mem_valid", mem_valid, 0);
    check("rst_payload", mem_payload, 0);
    check("rst_src", mem_src, 0);
    check("rst_cnt", outstanding, 0);
    check("rst_busy", fence_busy, 0);
    check("rst_done", fence_done, 0);
    check("rst_err", err, 0);

    // ---------------- RR fairness ----------------
    set_pay(0, 136'h100);
    set_pay(1, 136'h101);
    set_pay(2, 136'h102);
    rst_ni    = 1'b1;
    mem_ready = 1'b1;
    settle();
    check("rr_ready0", req_ready, 3'b001);
    tick();
    check("rr_src0", mem_src, 0);
    check("rr_pay0", mem_payload, 136'h100);
    check("rr_cnt0", outstanding, 1);
    rsp_valid = 1'b1;
    seq = '{1, 2, 0, 1, 2};
    for (int k = 0; k < 5; k++) begin
      settle();
      oh = 3'b001 << seq[k];
      check("rr_ready", req_ready, oh);
      tick();
      check("rr_src", mem_src, seq[k]);
      check("rr_cnt", outstanding, 1);
    end
    req_valid = '0;
    tick();
    check("rr_drain_valid", mem_valid, 0);
    check("rr_drain_cnt", outstanding, 0);
    rsp_valid = 1'b0;

    // ---------------- backpressure ----------------
    set_pay(1, 136'hA5);
    req_valid = 3'b010;
    settle();
    check("bp_ready1", req_ready, 3'b010);
    tick();
    check("bp_src", mem_src, 1);
    check("bp_pay", mem_payload, 136'hA5);
    mem_ready = 1'b0;
    req_valid = 3'b101;
    set_pay(0, 136'h50);
    set_pay(2, 136'h52);
    for (int k = 0; k < 5; k++) begin
      settle();
      check("bp_stall_ready", req_ready, 3'b000);
      tick();
      check("bp_stall_pay", mem_payload, 136'hA5);
      check("bp_stall_src", mem_src, 1);
      check("bp_stall_valid", mem_valid, 1);
    end
    mem_ready = 1'b1;
    settle();
    check("bp_release_ready", req_ready, 3'b100);
    tick();
    check("bp_next_src", mem_src, 2);
    check("bp_next_pay", mem_payload, 136'h52);
    check("bp_next_cnt", outstanding, 2);
    req_valid = '0;
    rsp_valid = 1'b1;
    tick();
    tick();
    check("bp_clean_cnt", outstanding, 0);
    rsp_valid = 1'b0;

    // ---------------- outstanding limit ----------------
    req_valid = 3'b001;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (req_ready[0]) acc++;
      tick();
    end
    check("lim_accepts", acc, 7);
    check("lim_cnt", outstanding, 7);
    settle();
    check("lim_ready_blocked", req_ready, 3'b000);
    rsp_valid = 1'b1;
    settle();
    check("lim_ready_rsp_cycle", req_ready, 3'b000);
    tick();
    check("lim_cnt_after_rsp", outstanding, 6);
    rsp_valid = 1'b0;
    settle();
    check("lim_ready_again", req_ready, 3'b001);
    tick();
    check("lim_cnt_back", outstanding, 7);
    settle();
    check("lim_ready_full", req_ready, 3'b000);
    req_valid = '0;
    rsp_valid = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    rsp_valid = 1'b0;
    check("lim_clean_cnt", outstanding, 0);
    check("lim_no_err", err, 0);

    // ---------------- simultaneous events ----------------
    req_valid = 3'b001;
    for (int k = 0; k < 3; k++) tick();
    check("sim_cnt3", outstanding, 3);
    rsp_valid = 1'b1;
    settle();
    check("sim_ready", req_ready, 3'b001);
    tick();
    check("sim_cnt_hold", outstanding, 3);
    req_valid = '0;
    for (int k = 0; k < 3; k++) tick();
    check("sim_cnt0", outstanding, 0);
    check("sim_err_clear", err, 0);
    tick();
    check("sim_cnt_underflow", outstanding, 0);
    check("sim_err_set", err, 1);
    rsp_valid = 1'b0;
    tick();
    check("sim_err_sticky", err, 1);

    // ---------------- fence drain ----------------
    req_valid = 3'b001;
    for (int k = 0; k < 3; k++) tick();
    check("fen_cnt3", outstanding, 3);
    req_valid = '0;
    fence = 1'b1;
    tick();
    fence = 1'b0;
    req_valid = 3'b100;
    check("fen_busy", fence_busy, 1);
    for (int k = 0; k < 3; k++) begin
      rsp_valid = 1'b1;
      settle();
      check("fen_no_accept", req_ready, 3'b000);
      tick();
      check("fen_cnt", outstanding, 2 - k);
      check("fen_busy_drain", fence_busy, 1);
      check("fen_done_early", fence_done, 0);
    end
    rsp_valid = 1'b0;
    settle();
    check("fen_no_accept_last", req_ready, 3'b000);
    tick();
    check("fen_done_pulse", fence_done, 1);
    settle();
    check("fen_no_accept_done", req_ready, 3'b000);
    tick();
    check("fen_done_clear", fence_done, 0);
    check("fen_busy_clear", fence_busy, 0);
    settle();
    check("fen_resume_ready", req_ready, 3'b100);
    tick();
    check("fen_resume_src", mem_src, 2);
    check("fen_resume_cnt", outstanding, 1);

    // ---------------- reset mid-burst ----------------
    req_valid = 3'b001;
    for (int k = 0; k < 4; k++) tick();
    check("mid_cnt5", outstanding, 5);
    check("mid_valid", mem_valid, 1);
    rst_ni = 1'b0;
    req_valid = 3'b111;
    settle();
    check("mid_ready_in_reset", req_ready, 3'b000);
    tick();
    check("mid_rst_valid", mem_valid, 0);
    check("mid_rst_payload", mem_payload, 0);
    check("mid_rst_src", mem_src, 0);
    check("mid_rst_cnt", outstanding, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_busy", fence_busy, 0);
    rst_ni = 1'b1;
    settle();
    check("mid_first_ready", req_ready, 3'b001);
    tick();
    check("mid_first_src", mem_src, 0);
    check("mid_first_pay", mem_payload, 136'h50);
    check("mid_first_cnt", outstanding, 1);

    // ---------------- fence with nothing pending ----------------
    req_valid = '0;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    check("idle_fen_cnt0", outstanding, 0);
    check("idle_fen_valid0", mem_valid, 0);
    fence = 1'b1;
    tick();
    fence = 1'b0;
    check("idle_fen_busy", fence_busy, 1);
    check("idle_fen_done_lo", fence_done, 0);
    tick();
    check("idle_fen_done_hi", fence_done, 1);
    tick();
    check("idle_fen_done_end", fence_done, 0);
    check("idle_fen_busy_end", fence_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
